// File: rtl/mat_tx_streamer.sv
// mat_tx_streamer -- streams a ROWS x COLS matrix of DW-bit elements from a
// synchronous-read memory to a byte-wide transmitter, LSB byte first, in
// row-major or column-major order, with a valid/ready byte handshake.
//
// Latency: launch lands 2 edges after start is first sampled high.
//   Each element then costs FETCH + LOAD + one cycle per byte while
//   tx_ready is held high, followed by a single DONE cycle.
// Backpressure: tx_valid is held high with tx_data stable until
//   tx_valid & tx_ready. No new read is issued until the current element's
//   bytes have all been accepted.
//
// Optional feature macro: MAT_TX_HEADER_EN. When defined, ROWS[7:0] and then
//   COLS[7:0] are sent as a two-byte header before the first element.
//
// Ports:
//   clk, rst         clock and async active-high reset
//   start, col_major launch request (level, may be async) and order select
//   rd_en, rd_addr   memory read strobe/address; rd_data valid next cycle
//   tx_valid/tx_data byte offered to the transmitter; tx_ready accepts it
//   busy, done       status: busy from launch to end of DONE, done pulse
module mat_tx_streamer #(
  parameter int ROWS = 2,
  parameter int COLS = 2,
  parameter int DW   = 8,
  parameter int AW   = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          col_major,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr,
  input  logic [DW-1:0] rd_data,
  output logic          tx_valid,
  output logic [7:0]    tx_data,
  input  logic          tx_ready,
  output logic          busy,
  output logic          done
);

  localparam int NB = DW / 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_FETCH,
    S_LOAD,
    S_SEND,
    S_DONE
  } state_t;

  state_t        r_state;
  logic          r_s1, r_s2, r_s3;
  logic          r_col_major;
  logic [7:0]    r_row, r_col;
  logic [DW-1:0] r_shreg;
  logic [2:0]    r_byte_cnt;
`ifdef MAT_TX_HEADER_EN
  logic          r_hdr_idx;
`endif

  logic       w_launch;
  logic       w_xfer;
  logic       w_last_byte;
  logic       w_row_end, w_col_end, w_last_elem;
  logic [7:0] w_nrow, w_ncol;

  // s1 is the metastability flop; the edge is detected between s2 and s3.
  assign w_launch    = r_s2 & ~r_s3 & (r_state == S_IDLE);
  assign w_xfer      = tx_valid & tx_ready;
  assign w_last_byte = (r_byte_cnt == 3'(NB - 1));
  assign w_row_end   = (r_row == 8'(ROWS - 1));
  assign w_col_end   = (r_col == 8'(COLS - 1));
  // The final element is (ROWS-1, COLS-1) in both orders.
  assign w_last_elem = w_row_end & w_col_end;

  // Next element coordinates; the inner counter depends on the order latched at launch.
  always_comb begin
    w_nrow = r_row;
    w_ncol = r_col;
    if (!r_col_major) begin
      if (w_col_end) begin
        w_ncol = 8'd0;
        w_nrow = r_row + 8'd1;
      end else begin
        w_ncol = r_col + 8'd1;
      end
    end else begin
      if (w_row_end) begin
        w_nrow = 8'd0;
        w_ncol = r_col + 8'd1;
      end else begin
        w_nrow = r_row + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_s1        <= 1'b0;
      r_s2        <= 1'b0;
      r_s3        <= 1'b0;
      r_col_major <= 1'b0;
      r_row       <= 8'd0;
      r_col       <= 8'd0;
      r_shreg     <= '0;
      r_byte_cnt  <= 3'd0;
`ifdef MAT_TX_HEADER_EN
      r_hdr_idx   <= 1'b0;
`endif
      rd_en       <= 1'b0;
      rd_addr     <= '0;
      tx_valid    <= 1'b0;
      tx_data     <= 8'd0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      r_s1 <= start;
      r_s2 <= r_s1;
      r_s3 <= r_s2;

      case (r_state)
        S_IDLE: begin
          if (w_launch) begin
            busy        <= 1'b1;
            r_col_major <= col_major;
            r_row       <= 8'd0;
            r_col       <= 8'd0;
            rd_addr     <= '0;
`ifdef MAT_TX_HEADER_EN
            r_state     <= S_HDR;
            r_hdr_idx   <= 1'b0;
            tx_valid    <= 1'b1;
            tx_data     <= 8'(ROWS);
`else
            r_state     <= S_FETCH;
            rd_en       <= 1'b1;
`endif
          end
        end

`ifdef MAT_TX_HEADER_EN
        S_HDR: begin
          if (w_xfer) begin
            if (!r_hdr_idx) begin
              r_hdr_idx <= 1'b1;
              tx_data   <= 8'(COLS);
            end else begin
              tx_valid  <= 1'b0;
              rd_en     <= 1'b1;
              r_state   <= S_FETCH;
            end
          end
        end
`endif

        S_FETCH: begin
          rd_en   <= 1'b0;
          r_state <= S_LOAD;
        end

        // rd_data is valid now (one cycle after rd_en); present byte 0 straight away.
        S_LOAD: begin
          r_shreg    <= rd_data;
          r_byte_cnt <= 3'd0;
          tx_data    <= rd_data[7:0];
          tx_valid   <= 1'b1;
          r_state    <= S_SEND;
        end

        S_SEND: begin
          if (w_xfer) begin
            r_shreg    <= r_shreg >> 8;
            tx_data    <= 8'(r_shreg >> 8);
            r_byte_cnt <= r_byte_cnt + 3'd1;
            if (w_last_byte) begin
              tx_valid <= 1'b0;
              if (w_last_elem) begin
                done    <= 1'b1;
                r_state <= S_DONE;
              end else begin
                r_row   <= w_nrow;
                r_col   <= w_ncol;
                rd_addr <= AW'(16'(w_nrow) * 16'(COLS) + 16'(w_ncol));
                rd_en   <= 1'b1;
                r_state <= S_FETCH;
              end
            end
          end
        end

        S_DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mat_tx_streamer.sv
// Directed bench for mat_tx_streamer: three instances (2x2x8, 1x2x16, 3x2x8),
// each with its own synchronous-read memory model and negedge byte monitor.
module tb_mat_tx_streamer;

`ifdef MAT_TX_HEADER_EN
  localparam int HB = 2;
`else
  localparam int HB = 0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks;
  int errors;

  // ---------------- DUT A: 2x2, 8-bit ----------------
  logic       start_a, cm_a, rd_en_a, tx_valid_a, tx_ready_a, busy_a, done_a;
  logic [5:0] rd_addr_a;
  logic [7:0] rd_data_a, tx_data_a;
  logic [7:0] mem_a[64];

  mat_tx_streamer #(.ROWS(2), .COLS(2), .DW(8), .AW(6)) u_a (
    .clk(clk), .rst(rst), .start(start_a), .col_major(cm_a),
    .rd_en(rd_en_a), .rd_addr(rd_addr_a), .rd_data(rd_data_a),
    .tx_valid(tx_valid_a), .tx_data(tx_data_a), .tx_ready(tx_ready_a),
    .busy(busy_a), .done(done_a));

  // ---------------- DUT B: 1x2, 16-bit ----------------
  logic        start_b, cm_b, rd_en_b, tx_valid_b, tx_ready_b, busy_b, done_b;
  logic [5:0]  rd_addr_b;
  logic [15:0] rd_data_b;
  logic [7:0]  tx_data_b;
  logic [15:0] mem_b[64];

  mat_tx_streamer #(.ROWS(1), .COLS(2), .DW(16), .AW(6)) u_b (
    .clk(clk), .rst(rst), .start(start_b), .col_major(cm_b),
    .rd_en(rd_en_b), .rd_addr(rd_addr_b), .rd_data(rd_data_b),
    .tx_valid(tx_valid_b), .tx_data(tx_data_b), .tx_ready(tx_ready_b),
    .busy(busy_b), .done(done_b));

  // ---------------- DUT C: 3x2, 8-bit ----------------
  logic       start_c, cm_c, rd_en_c, tx_valid_c, tx_ready_c, busy_c, done_c;
  logic [5:0] rd_addr_c;
  logic [7:0] rd_data_c, tx_data_c;
  logic [7:0] mem_c[64];

  mat_tx_streamer #(.ROWS(3), .COLS(2), .DW(8), .AW(6)) u_c (
    .clk(clk), .rst(rst), .start(start_c), .col_major(cm_c),
    .rd_en(rd_en_c), .rd_addr(rd_addr_c), .rd_data(rd_data_c),
    .tx_valid(tx_valid_c), .tx_data(tx_data_c), .tx_ready(tx_ready_c),
    .busy(busy_c), .done(done_c));

  // Synchronous-read memories: data valid the cycle after rd_en.
  always @(posedge clk) begin
    if (rd_en_a) rd_data_a <= mem_a[rd_addr_a];
    if (rd_en_b) rd_data_b <= mem_b[rd_addr_b];
    if (rd_en_c) rd_data_c <= mem_c[rd_addr_c];
  end

  // B's ready is high one cycle in three.
  int cyc_b = 0;
  always @(posedge clk) begin
    #1;
    cyc_b++;
    tx_ready_b = (cyc_b % 3 == 0);
  end

  // Monitors: sample mid-cycle; a transfer seen here completes on the next posedge.
  logic [7:0] q_a[$];
  logic [5:0] q_addr_a[$];
  logic [7:0] q_b[$];
  logic [7:0] q_c[$];
  int done_cnt_a;
  int stalls_b;
  logic hold_b = 1'b0;
  logic [7:0] held_b = 8'd0;

  always @(negedge clk) begin
    if (tx_valid_a && tx_ready_a) q_a.push_back(tx_data_a);
    if (rd_en_a) q_addr_a.push_back(rd_addr_a);
    if (done_a) done_cnt_a++;
    if (tx_valid_b && tx_ready_b) q_b.push_back(tx_data_b);
    if (tx_valid_c && tx_ready_c) q_c.push_back(tx_data_c);
    if (hold_b) begin
      checks++;
      if (!(tx_valid_b && tx_data_b == held_b)) begin
        errors++;
        $display("FAIL b_stall_stable: valid=%0b data=%02h required valid=1 data=%02h",
                 tx_valid_b, tx_data_b, held_b);
      end
    end
    hold_b = tx_valid_b && !tx_ready_b;
    held_b = tx_data_b;
    if (hold_b) stalls_b++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic wait_done(input int which, input int budget, input string tag);
    bit seen = 1'b0;
    for (int n = 0; n < budget && !seen; n++) begin
      @(negedge clk);
      case (which)
        0:       seen = done_a;
        1:       seen = done_b;
        default: seen = done_c;
      endcase
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s: no done within %0d cycles", tag, budget);
    end
  endtask

  task automatic wait_valid_a(input int budget, input string tag);
    bit seen = 1'b0;
    for (int n = 0; n < budget && !seen; n++) begin
      @(negedge clk);
      seen = tx_valid_a;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s: no tx_valid within %0d cycles", tag, budget);
    end
  endtask

  task automatic clear_a();
    q_a.delete();
    q_addr_a.delete();
    done_cnt_a = 0;
  endtask

  typedef struct packed {
    logic            cm;
    logic [3:0][7:0] mem;
    logic [3:0][7:0] exp;
    logic [3:0][5:0] addr;
  } vec_t;

  vec_t vt[4];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] got;
    int act;

    vt[0] = '{cm: 1'b0, mem: {8'h44, 8'h33, 8'h22, 8'h11},
              exp: {8'h44, 8'h33, 8'h22, 8'h11}, addr: {6'd3, 6'd2, 6'd1, 6'd0}};
    vt[1] = '{cm: 1'b1, mem: {8'h44, 8'h33, 8'h22, 8'h11},
              exp: {8'h44, 8'h22, 8'h33, 8'h11}, addr: {6'd3, 6'd1, 6'd2, 6'd0}};
    vt[2] = '{cm: 1'b0, mem: {8'hFF, 8'h00, 8'h5A, 8'hA5},
              exp: {8'hFF, 8'h00, 8'h5A, 8'hA5}, addr: {6'd3, 6'd2, 6'd1, 6'd0}};
    vt[3] = '{cm: 1'b1, mem: {8'h04, 8'h03, 8'h02, 8'h01},
              exp: {8'h04, 8'h02, 8'h03, 8'h01}, addr: {6'd3, 6'd1, 6'd2, 6'd0}};

    checks = 0;
    errors = 0;
    done_cnt_a = 0;
    stalls_b = 0;
    for (int i = 0; i < 64; i++) begin
      mem_a[i] = 8'hEE;
      mem_b[i] = 16'hEEEE;
      mem_c[i] = 8'hEE;
    end
    mem_b[0] = 16'hA1B2;
    mem_b[1] = 16'hC3D4;
    for (int i = 0; i < 6; i++) mem_c[i] = 8'h10 + 8'(i);

    rst = 1'b1;
    start_a = 0; cm_a = 0; tx_ready_a = 0;
    start_b = 0; cm_b = 0;
    start_c = 0; cm_c = 0; tx_ready_c = 1;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_rd_en", {31'd0, rd_en_a}, 0);
    chk("rst_rd_addr", {26'd0, rd_addr_a}, 0);
    chk("rst_tx", {23'd0, tx_valid_a, tx_data_a}, 0);
    chk("rst_busy_done", {30'd0, busy_a, done_a}, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Table-driven transfers on A
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) mem_a[j] = vt[i].mem[j];
      clear_a();
      tx_ready_a = 1;
      cm_a = vt[i].cm;
      start_a = 1;
      repeat (4) @(negedge clk);
      cm_a = ~vt[i].cm;          // must be ignored after launch
      wait_done(0, 200, "vec_done");
      start_a = 0;
      repeat (3) @(negedge clk);
      chk($sformatf("vec%0d_nbytes", i), q_a.size(), HB + 4);
      if (HB != 0 && q_a.size() >= 2) begin
        chk($sformatf("vec%0d_hdr_rows", i), {24'd0, q_a[0]}, 2);
        chk($sformatf("vec%0d_hdr_cols", i), {24'd0, q_a[1]}, 2);
      end
      for (int j = 0; j < 4; j++) begin
        got = (q_a.size() > HB + j) ? q_a[HB + j] : 8'hEE;
        chk($sformatf("vec%0d_byte%0d", i, j), {24'd0, got}, {24'd0, vt[i].exp[j]});
      end
      chk($sformatf("vec%0d_nreads", i), q_addr_a.size(), 4);
      for (int j = 0; j < 4; j++) begin
        act = (q_addr_a.size() > j) ? int'(q_addr_a[j]) : 99;
        chk($sformatf("vec%0d_addr%0d", i, j), act, {26'd0, vt[i].addr[j]});
      end
      chk($sformatf("vec%0d_done_pulses", i), done_cnt_a, 1);
      chk($sformatf("vec%0d_busy_after", i), {31'd0, busy_a}, 0);
    end

    // DUT B: 16-bit elements, LSB first, under throttled ready
    q_b.delete();
    start_b = 1;
    wait_done(1, 400, "b_done");
    start_b = 0;
    repeat (3) @(negedge clk);
    chk("b_nbytes", q_b.size(), HB + 4);
    begin
      logic [7:0] eb[6];
      eb = '{8'h01, 8'h02, 8'hB2, 8'hA1, 8'hD4, 8'hC3};
      for (int j = 0; j < HB + 4; j++) begin
        got = (q_b.size() > j) ? q_b[j] : 8'hEE;
        chk($sformatf("b_byte%0d", j), {24'd0, got}, {24'd0, eb[j + 2 - HB]});
      end
    end
    chk("b_saw_stalls", {31'd0, stalls_b > 0}, 1);

    // DUT C: 3x2 row-major
    q_c.delete();
    start_c = 1;
    wait_done(2, 400, "c_done");
    start_c = 0;
    repeat (3) @(negedge clk);
    chk("c_nbytes", q_c.size(), HB + 6);
    if (HB != 0 && q_c.size() >= 2) begin
      chk("c_hdr_rows", {24'd0, q_c[0]}, 3);
      chk("c_hdr_cols", {24'd0, q_c[1]}, 2);
    end
    for (int j = 0; j < 6; j++) begin
      got = (q_c.size() > HB + j) ? q_c[HB + j] : 8'hEE;
      chk($sformatf("c_byte%0d", j), {24'd0, got}, 32'h10 + j);
    end

    // Second start edge mid-transfer is discarded
    for (int j = 0; j < 4; j++) mem_a[j] = vt[0].mem[j];
    cm_a = 0;
    clear_a();
    start_a = 1;
    repeat (6) @(negedge clk);
    start_a = 0;
    repeat (2) @(negedge clk);
    start_a = 1;
    wait_done(0, 200, "mid_done");
    repeat (15) @(negedge clk);
    chk("mid_nbytes", q_a.size(), HB + 4);
    chk("mid_done_pulses", done_cnt_a, 1);
    chk("mid_busy_after", {31'd0, busy_a}, 0);
    start_a = 0;
    repeat (3) @(negedge clk);

    // Start edge one cycle after done launches a second full transfer
    clear_a();
    start_a = 1;
    repeat (6) @(negedge clk);
    start_a = 0;
    wait_done(0, 200, "b2b_done1");
    @(posedge clk);
    #1 start_a = 1;
    wait_done(0, 200, "b2b_done2");
    start_a = 0;
    repeat (3) @(negedge clk);
    chk("b2b_nbytes", q_a.size(), 2 * (HB + 4));
    chk("b2b_nreads", q_addr_a.size(), 8);
    chk("b2b_done_pulses", done_cnt_a, 2);

    // Reset during the third byte
    clear_a();
    tx_ready_a = 0;
    start_a = 1;
    for (int k = 0; k < 2; k++) begin
      wait_valid_a(50, "rst_step_valid");
      tx_ready_a = 1;
      @(posedge clk);
      #1 tx_ready_a = 0;
    end
    wait_valid_a(50, "rst_third_valid");
    start_a = 0;
    rst = 1'b1;
    #1;
    chk("midrst_rd", {25'd0, rd_en_a, rd_addr_a}, 0);
    chk("midrst_tx", {23'd0, tx_valid_a, tx_data_a}, 0);
    chk("midrst_status", {30'd0, busy_a, done_a}, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    tx_ready_a = 1;
    act = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (rd_en_a || tx_valid_a || busy_a || done_a) act++;
    end
    chk("post_rst_quiet", act, 0);
    chk("post_rst_nbytes", q_a.size(), 2);

    // start held high across reset release launches exactly one transfer
    clear_a();
    start_a = 1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    wait_done(0, 200, "held_done");
    repeat (15) @(negedge clk);
    chk("held_nbytes", q_a.size(), HB + 4);
    chk("held_done_pulses", done_cnt_a, 1);
    start_a = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
